multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Multi-cycle control unit for the MIPS core, replacing the single-cycle decoder. It sequences each instruction through fetch, decode, execute, memory and write-back states over a shared memory and ALU. It drives Moore-style control strobes to the datapath and includes a parametrised ALU-operation decoder. An optional memory-ready handshake supports wait states.

## Interface
Parameters:
- ALU_OP_W, 3, width of alu_operation; must be ≥3.
- STATE_W, 4, width of the state register and of the state debug output; must be ≥4.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- opcode  in  6  IR[31:26]; valid from DECODE onward.
- func  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory handshake; present only with MEM_WAIT_EN.
- pc_en  out  1  PC load enable = pc_write | (pc_write_cond & zero).
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read, mem_write, ir_write  out  1 each  memory and IR strobes.
- mem_to_reg  out  1  write-back data select: 1 = MDR.
- data_to_write  out  1  write-back data select: 1 = PC (jal).
- reg_dst  out  2  destination register: 0 = rt, 1 = rd, 2 = $31.
- reg_write  out  1  register-file write enable.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = rs.
- alu_src_b  out  2  ALU B select: 0 = rt, 1 = constant 4, 2 = sign-extended immediate, 3 = immediate << 2.
- alu_operation  out  ALU_OP_W  ALU operation: 0 add, 1 sub, 2 and, 3 or, 4 slt; zero-extended to ALU_OP_W.
- pc_src  out  2  PC next-value select: 0 = ALU result, 1 = ALUOut, 2 = jump target, 3 = rs.
- instr_done  out  1  one-cycle pulse in the final state of each instruction.
- illegal_op  out  1  one-cycle pulse in DECODE when the opcode is undefined.
- state  out  STATE_W  current state, for debug.

## Operation
- Opcodes:
  - 000000 R-type.
  - 000001 addi.
  - 000010 slti.
  - 000011 lw.
  - 000100 sw.
  - 000101 beq.
  - 000110 j.
  - 000111 jr.
  - 001000 jal.
- R-type func decode: 000001 add, 000010 sub, 000100 and, 001000 or, 010000 slt. Any other func → add.
- States and transitions:
  - FETCH: mem_read=1, ir_write=1, alu_src_b=1, add, pc_write. Next: DECODE.
  - DECODE: alu_src_b=3, add (precomputes the branch target). Next by opcode:
    - lw, sw → MEM_ADDR.
    - R-type → EXEC_R.
    - addi, slti → EXEC_I.
    - beq → BRANCH.
    - j → JUMP.
    - jr → JR.
    - jal → JAL.
    - Undefined opcode → FETCH, with illegal_op pulsed.
  - MEM_ADDR: alu_src_a=1, alu_src_b=2, add. Next: MEM_RD for lw, MEM_WR for sw.
  - MEM_RD: iord=1, mem_read=1. Next: WB_MEM.
  - WB_MEM: reg_write=1, mem_to_reg=1, reg_dst=0. Next: FETCH.
  - MEM_WR: iord=1, mem_write=1. Next: FETCH.
  - EXEC_R: alu_src_a=1, alu_src_b=0, func-decoded operation. Next: WB_R.
  - WB_R: reg_write=1, reg_dst=1. Next: FETCH.
  - EXEC_I: alu_src_a=1, alu_src_b=2; operation is add for addi, slt for slti. Next: WB_I.
  - WB_I: reg_write=1, reg_dst=0. Next: FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=0, sub, pc_write_cond=1, pc_src=1. Next: FETCH.
  - JUMP: pc_write=1, pc_src=2. Next: FETCH.
  - JR: pc_write=1, pc_src=3. Next: FETCH.
  - JAL: pc_write=1, pc_src=2, reg_write=1, reg_dst=2, data_to_write=1. Next: FETCH.
- Every signal not listed for a state is 0 in that state.
- instr_done is high in WB_MEM, MEM_WR, WB_R, WB_I, BRANCH, JUMP, JR and JAL.
- Unused state encodings go to FETCH on the next edge, with all outputs 0 while in them.

## Timing
- Reset:
  - The state register resets to FETCH asynchronously.
  - While rst_n=0, every output is forced to 0 and state reads FETCH.
  - The first fetch strobes appear in the cycle after rst_n rises.
- Reset asserted mid-instruction aborts the instruction immediately; no write strobe is issued after the asserting edge.
- All outputs are combinational decodes of the registered state. pc_en additionally depends combinationally on zero.
- Latency in cycles, without wait states:
  - lw: 5.
  - R-type, addi, slti, sw: 4.
  - beq, j, jr, jal: 3.
  - Undefined opcode: 2.
- opcode and func must be stable from DECODE until the instruction's final state.

## Configuration
- MEM_WAIT_EN defined:
  - FETCH, MEM_RD and MEM_WR stay in their state until mem_ready=1.
  - In FETCH, ir_write and pc_write are gated by mem_ready.
  - mem_read and mem_write stay high for the whole wait.
  - Each cycle with mem_ready=0 adds one cycle of latency.
- MEM_WAIT_EN undefined:
  - The mem_ready port is absent.
  - The memory states always last exactly one cycle.

## Test plan
- Reset, then run with opcode=000000, func=000010 → state sequence FETCH, DECODE, EXEC_R, WB_R, FETCH. alu_operation=1 in EXEC_R; reg_write=1 and reg_dst=1 in WB_R; instr_done pulses in cycle 4.
- lw (000011) → 5 cycles. iord=1 and mem_read=1 in MEM_RD; mem_to_reg=1 and reg_write=1 in WB_MEM.
- beq with zero=0, then beq with zero=1 → pc_en=0 and pc_en=1 respectively in BRANCH; both take 3 cycles.
- jal (001000) → in JAL: reg_dst=2, data_to_write=1, reg_write=1, pc_src=2, pc_en=1.
- Opcode 111111 → illegal_op pulses in DECODE, return to FETCH, no reg_write or mem_write issued. Drive rst_n low during MEM_WR → mem_write drops to 0 immediately.
- With MEM_WAIT_EN, hold mem_ready=0 for 3 cycles in FETCH → ir_write and pc_en stay 0 until mem_ready=1; the R-type instruction completes in 7 cycles.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back over a shared memory and ALU.
// Define MEM_WAIT_EN to add the mem_ready wait-state handshake on FETCH, MEM_RD and MEM_WR.
module multicycle_controller #(
  parameter int unsigned ALU_OP_W = 3,
  parameter int unsigned STATE_W  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          opcode,
  input  logic [5:0]          func,
  input  logic                zero,
`ifdef MEM_WAIT_EN
  input  logic                mem_ready,
`endif
  output logic                pc_en,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mem_to_reg,
  output logic                data_to_write,
  output logic [1:0]          reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_operation,
  output logic [1:0]          pc_src,
  output logic                instr_done,
  output logic                illegal_op,
  output logic [STATE_W-1:0]  state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b000001;
  localparam logic [5:0] OP_SLTI  = 6'b000010;
  localparam logic [5:0] OP_LW    = 6'b000011;
  localparam logic [5:0] OP_SW    = 6'b000100;
  localparam logic [5:0] OP_BEQ   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000110;
  localparam logic [5:0] OP_JR    = 6'b000111;
  localparam logic [5:0] OP_JAL   = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = STATE_W'(0),
    S_DECODE   = STATE_W'(1),
    S_MEM_ADDR = STATE_W'(2),
    S_MEM_RD   = STATE_W'(3),
    S_WB_MEM   = STATE_W'(4),
    S_MEM_WR   = STATE_W'(5),
    S_EXEC_R   = STATE_W'(6),
    S_WB_R     = STATE_W'(7),
    S_EXEC_I   = STATE_W'(8),
    S_WB_I     = STATE_W'(9),
    S_BRANCH   = STATE_W'(10),
    S_JUMP     = STATE_W'(11),
    S_JR       = STATE_W'(12),
    S_JAL      = STATE_W'(13)
  } state_t;

  state_t     state_q, state_d;
  logic       mem_ok;
  logic       pc_write, pc_write_cond;
  logic [2:0] r_op, alu_op;

`ifdef MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  assign mem_ok = 1'b1;
`endif

  // R-type function field to ALU operation; unknown codes fall back to add
  always_comb begin
    case (func)
      6'b000010: r_op = ALU_SUB;
      6'b000100: r_op = ALU_AND;
      6'b001000: r_op = ALU_OR;
      6'b010000: r_op = ALU_SLT;
      default:   r_op = ALU_ADD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next state and Moore strobes; everything held at 0 while reset is asserted
  always_comb begin
    state_d       = state_q;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    data_to_write = 1'b0;
    reg_dst       = 2'd0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_op        = ALU_ADD;
    pc_src        = 2'd0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          ir_write  = mem_ok;
          pc_write  = mem_ok;
          alu_src_b = 2'd1;
          if (mem_ok) state_d = S_DECODE;
        end
        S_DECODE: begin
          alu_src_b = 2'd3;
          case (opcode)
            OP_LW, OP_SW:     state_d = S_MEM_ADDR;
            OP_RTYPE:         state_d = S_EXEC_R;
            OP_ADDI, OP_SLTI: state_d = S_EXEC_I;
            OP_BEQ:           state_d = S_BRANCH;
            OP_J:             state_d = S_JUMP;
            OP_JR:            state_d = S_JR;
            OP_JAL:           state_d = S_JAL;
            default: begin
              state_d    = S_FETCH;
              illegal_op = 1'b1;
            end
          endcase
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
          state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
        end
        S_MEM_RD: begin
          iord     = 1'b1;
          mem_read = 1'b1;
          if (mem_ok) state_d = S_WB_MEM;
        end
        S_WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_MEM_WR: begin
          iord       = 1'b1;
          mem_write  = 1'b1;
          instr_done = mem_ok;
          if (mem_ok) state_d = S_FETCH;
        end
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = r_op;
          state_d   = S_WB_R;
        end
        S_WB_R: begin
          reg_write  = 1'b1;
          reg_dst    = 2'd1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
          alu_op    = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
          state_d   = S_WB_I;
        end
        S_WB_I: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_src        = 2'd1;
          instr_done    = 1'b1;
          state_d       = S_FETCH;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_src     = 2'd2;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_JR: begin
          pc_write   = 1'b1;
          pc_src     = 2'd3;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_JAL: begin
          pc_write      = 1'b1;
          pc_src        = 2'd2;
          reg_write     = 1'b1;
          reg_dst       = 2'd2;
          data_to_write = 1'b1;
          instr_done    = 1'b1;
          state_d       = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  assign pc_en         = pc_write | (pc_write_cond & zero);
  assign alu_operation = ALU_OP_W'(alu_op);
  assign state         = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected state and strobe word queued per instruction.
// Define MEM_WAIT_EN to also cover the mem_ready wait-state path.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic [5:0] func = 6'd0;
  logic       zero = 1'b0;
`ifdef MEM_WAIT_EN
  logic       mem_ready = 1'b1;
`endif
  logic       pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, data_to_write;
  logic [1:0] reg_dst, alu_src_b, pc_src;
  logic       reg_write, alu_src_a, instr_done, illegal_op;
  logic [2:0] alu_operation;
  logic [3:0] state;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func), .zero(zero),
`ifdef MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .data_to_write(data_to_write),
    .reg_dst(reg_dst), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_operation(alu_operation), .pc_src(pc_src),
    .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  // Strobe word bit positions
  localparam logic [19:0] PCEN = 20'h80000, IORD = 20'h40000, MR  = 20'h20000, MW   = 20'h10000;
  localparam logic [19:0] IRW  = 20'h08000, M2R  = 20'h04000, D2W = 20'h02000, RW   = 20'h00400;
  localparam logic [19:0] SA   = 20'h00200, DONE = 20'h00002, ILL = 20'h00001;

  function automatic logic [19:0] rd(input int v);  return 20'(v) << 11; endfunction
  function automatic logic [19:0] sb(input int v);  return 20'(v) << 7;  endfunction
  function automatic logic [19:0] aop(input int v); return 20'(v) << 4;  endfunction
  function automatic logic [19:0] ps(input int v);  return 20'(v) << 2;  endfunction

  typedef struct packed { logic [3:0] st; logic [19:0] w; } exp_t;
  exp_t  sb_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  string cur_tag = "reset";

  function automatic logic [19:0] dut_word();
    return {pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, data_to_write,
            reg_dst, reg_write, alu_src_a, alu_src_b, alu_operation, pc_src,
            instr_done, illegal_op};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int st, input logic [19:0] w);
    exp_t e;
    e.st = 4'(st);
    e.w  = w;
    sb_q.push_back(e);
  endtask

  // Expected func decode straight from the opcode table
  function automatic int func_op(input logic [5:0] fn);
    case (fn)
      6'b000001: return 0;
      6'b000010: return 1;
      6'b000100: return 2;
      6'b001000: return 3;
      6'b010000: return 4;
      default:   return 0;
    endcase
  endfunction

  task automatic push_seq(input logic [5:0] op, input logic [5:0] fn, input logic z);
    push(0, PCEN | MR | IRW | sb(1));
    push(1, sb(3) | ((op > 6'd8) ? ILL : 20'd0));
    case (op)
      6'd0: begin push(6, SA | aop(func_op(fn))); push(7, RW | rd(1) | DONE); end
      6'd1: begin push(8, SA | sb(2));            push(9, RW | DONE); end
      6'd2: begin push(8, SA | sb(2) | aop(4));   push(9, RW | DONE); end
      6'd3: begin push(2, SA | sb(2)); push(3, IORD | MR); push(4, RW | M2R | DONE); end
      6'd4: begin push(2, SA | sb(2)); push(5, IORD | MW | DONE); end
      6'd5: push(10, SA | aop(1) | ps(1) | DONE | (z ? PCEN : 20'd0));
      6'd6: push(11, PCEN | ps(2) | DONE);
      6'd7: push(12, PCEN | ps(3) | DONE);
      6'd8: push(13, PCEN | ps(2) | RW | rd(2) | D2W | DONE);
      default: ;
    endcase
  endtask

  task automatic drain(input int n);
    exp_t e;
    repeat (n) begin
      @(negedge clk);
      if (sb_q.size() == 0) begin
        check({cur_tag, " queue"}, 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check({cur_tag, " state"}, 32'(state), 32'(e.st));
        check({cur_tag, " strobes"}, 32'(dut_word()), 32'(e.w));
      end
    end
  endtask

  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn, input logic z);
    int n;
    cur_tag = tag;
    push_seq(op, fn, z);
    n = sb_q.size();
    drain(1);
    opcode = op;
    func   = fn;
    zero   = z;
    drain(n - 1);
  endtask

  task automatic hold_reset();
    rst_n = 1'b0;
    @(negedge clk);
    check("rst state", 32'(state), 32'd0);
    check("rst strobes", 32'(dut_word()), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    hold_reset();
    run_instr("r_sub",  6'b000000, 6'b000010, 1'b0);
    run_instr("r_add",  6'b000000, 6'b000001, 1'b0);
    run_instr("r_and",  6'b000000, 6'b000100, 1'b1);
    run_instr("r_or",   6'b000000, 6'b001000, 1'b0);
    run_instr("r_slt",  6'b000000, 6'b010000, 1'b0);
    run_instr("r_unk",  6'b000000, 6'b100011, 1'b0);
    run_instr("addi",   6'b000001, 6'b010000, 1'b0);
    run_instr("slti",   6'b000010, 6'b000000, 1'b0);
    run_instr("lw",     6'b000011, 6'b000000, 1'b1);
    run_instr("sw",     6'b000100, 6'b000000, 1'b0);
    run_instr("beq_z0", 6'b000101, 6'b000000, 1'b0);
    run_instr("beq_z1", 6'b000101, 6'b000000, 1'b1);
    run_instr("j",      6'b000110, 6'b000000, 1'b1);
    run_instr("jr",     6'b000111, 6'b000000, 1'b0);
    run_instr("jal",    6'b001000, 6'b000000, 1'b0);
    run_instr("ill_3f", 6'b111111, 6'b000000, 1'b0);
    run_instr("ill_09", 6'b001001, 6'b000000, 1'b1);
    run_instr("r_after_ill", 6'b000000, 6'b001000, 1'b0);

    // Abort a store in MEM_WR: strobes must drop as soon as reset asserts
    cur_tag = "sw_abort";
    push_seq(6'b000100, 6'b000000, 1'b0);
    drain(1);
    opcode = 6'b000100;
    drain(3);
    #1 rst_n = 1'b0;
    #1;
    check("abort mem_write", 32'(mem_write), 32'd0);
    check("abort strobes", 32'(dut_word()), 32'd0);
    check("abort state", 32'(state), 32'd0);
    @(negedge clk);
    check("abort hold strobes", 32'(dut_word()), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    run_instr("r_after_rst", 6'b000000, 6'b000010, 1'b0);

`ifdef MEM_WAIT_EN
    // Three FETCH cycles without mem_ready, then the R-type completes in 7 cycles
    cur_tag = "fetch_wait";
    opcode = 6'b000000;
    func   = 6'b000100;
    @(posedge clk);
    #1 mem_ready = 1'b0;
    repeat (3) push(0, MR | sb(1));
    push_seq(6'b000000, 6'b000100, 1'b0);
    drain(3);
    @(posedge clk);
    #1 mem_ready = 1'b1;
    drain(4);
`endif

    check("queue empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
